// File: rtl/b2r_pingpong_converter.sv
// Block-to-row converter: gathers square blocks of a ROW x COL matrix into a ping-pong buffer, emits row-major rows.
// Latency: out_valid rises the cycle after the final input beat of a matrix when the reader is on that bank.
// Backpressure: in_ready low while the write bank is still full; out_data holds while out_valid && !out_ready.
//
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_data carry NUM_CORES blocks per beat;
//        out_valid/out_ready/out_data carry one matrix row (column k at [k*WIDTH +: WIDTH]);
//        done pulses for one cycle after the last row of a matrix is accepted.
module b2r_pingpong_converter #(
  parameter int WIDTH      = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int ROW        = 8,
  parameter int COL        = 6,
  parameter int BLOCK_SIZE = 2,
  parameter int NUM_CORES  = 2
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 in_valid,
  output logic                                                 in_ready,
  input  logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE*NUM_CORES-1:0]     in_data,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic [WIDTH*COL-1:0]                                 out_data,
  output logic                                                 done
);

  localparam int CHUNK_SIZE     = BLOCK_SIZE * BLOCK_SIZE;
  localparam int ELEM_PER_INPUT = CHUNK_SIZE * NUM_CORES;
  localparam int BLK_PER_ROW    = COL / BLOCK_SIZE;
  localparam int BEATS          = (ROW * COL) / ELEM_PER_INPUT;
  localparam int DEPTH          = ROW * COL;
  localparam int AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW             = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RW             = (ROW > 1) ? $clog2(ROW) : 1;

  // Geometry must tile exactly; the fraction field has to fit inside an element.
  if ((ROW % BLOCK_SIZE) != 0 || (COL % BLOCK_SIZE) != 0 ||
      (((ROW / BLOCK_SIZE) * BLK_PER_ROW) % NUM_CORES) != 0 || FRAC_WIDTH > WIDTH) begin : g_bad_geometry
    $error("b2r_pingpong_converter: illegal ROW/COL/BLOCK_SIZE/NUM_CORES/FRAC_WIDTH combination");
  end

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [RW-1:0]    row_cnt_q, row_cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [WIDTH-1:0] mem_d [2][DEPTH];

  logic in_hs;
  logic out_hs;

  // Row-major storage address of element j of core c in the given beat.
  function automatic logic [AW-1:0] wr_addr(input logic [BW-1:0] beat, input int c, input int j);
    int g;
    int r;
    int k;
    g = int'(beat) * NUM_CORES + c;
    r = (g / BLK_PER_ROW) * BLOCK_SIZE + j / BLOCK_SIZE;
    k = (g % BLK_PER_ROW) * BLOCK_SIZE + j % BLOCK_SIZE;
    return AW'(r * COL + k);
  endfunction

  function automatic logic [AW-1:0] rd_addr(input logic [RW-1:0] row, input int k);
    return AW'(int'(row) * COL + k);
  endfunction

  assign in_ready  = !rst && !full_q[wr_bank_q];
  // Gated by rst so the output is quiet before the first reset edge has cleared the flags.
  assign out_valid = !rst && full_q[rd_bank_q];
  assign done      = done_q;
  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  // Scatter one beat of blocks into the write bank.
  always_comb begin
    mem_d = mem_q;
    if (in_hs) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        for (int j = 0; j < CHUNK_SIZE; j++) begin
          mem_d[wr_bank_q][wr_addr(beat_cnt_q, c, j)] = in_data[(c*CHUNK_SIZE+j)*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < COL; k++) begin
      out_data[k*WIDTH +: WIDTH] = mem_q[rd_bank_q][rd_addr(row_cnt_q, k)];
    end
  end

  always_comb begin
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    beat_cnt_d = beat_cnt_q;
    row_cnt_d  = row_cnt_q;
    done_d     = 1'b0;
    // Writer sets and reader clears always target different banks, so both apply.
    if (in_hs) begin
      if (beat_cnt_q == BW'(BEATS - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        beat_cnt_d        = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
    if (out_hs) begin
      if (row_cnt_q == RW'(ROW - 1)) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        row_cnt_d         = '0;
        done_d            = 1'b1;
      end else begin
        row_cnt_d = row_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      beat_cnt_q <= '0;
      row_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      beat_cnt_q <= beat_cnt_d;
      row_cnt_q  <= row_cnt_d;
      done_q     <= done_d;
    end
  end

  // Matrix storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_b2r_pingpong_converter.sv
module tb_b2r_pingpong_converter;

  logic clk;
  logic rst;

  // Instance A: default geometry (8x6, 2x2 blocks, 2 cores, 6 beats)
  logic         in_valid_a, in_ready_a, out_valid_a, out_ready_a, done_a;
  logic [127:0] in_data_a;
  logic [95:0]  out_data_a;
  // Instance B: 4x8, 2x2 blocks, 4 cores, 2 beats
  logic         in_valid_b, in_ready_b, out_valid_b, out_ready_b, done_b;
  logic [255:0] in_data_b;
  logic [127:0] out_data_b;

  b2r_pingpong_converter dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .done(done_a)
  );

  b2r_pingpong_converter #(.WIDTH(16), .FRAC_WIDTH(8), .ROW(4), .COL(8), .BLOCK_SIZE(2), .NUM_CORES(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .done(done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  logic [95:0]  q_a[$];
  logic [127:0] q_b[$];
  int pops_a = 0, pops_b = 0, done_cnt_a = 0, done_cnt_b = 0;
  int row_idx_a = 0, row_idx_b = 0, cap_base_a = 0;
  logic done_exp_a = 1'b0, done_exp_b = 1'b0, seen_rst_a = 1'b0, seen_rst_b = 1'b0;
  logic [95:0] cap0_a, cap1_a;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stream element n -> (row, col) of the matrix.
  function automatic void map_pos(input int n, input int col, input int bs, input int nc,
                                  output int r, output int k);
    int chunk, epi, b, e, c, j, g, bpr;
    chunk = bs * bs;
    epi   = chunk * nc;
    b = n / epi;  e = n % epi;
    c = e / chunk; j = e % chunk;
    g = b * nc + c;
    bpr = col / bs;
    r = (g / bpr) * bs + j / bs;
    k = (g % bpr) * bs + j % bs;
  endfunction

  // Output scoreboards: compare the presented row (also while stalled) and the done pulse timing.
  always @(negedge clk) begin
    if (rst) begin
      seen_rst_a = 1'b1; done_exp_a = 1'b0; row_idx_a = 0;
    end else if (seen_rst_a) begin
      chk("a_done", done_a, done_exp_a);
      if (done_a) done_cnt_a++;
      done_exp_a = 1'b0;
      if (out_valid_a) begin
        if (q_a.size() == 0) chk("a_spurious_valid", out_valid_a, 1'b0);
        else begin
          chk("a_row", out_data_a, q_a[0]);
          if (out_ready_a) begin
            if (pops_a == cap_base_a) cap0_a = out_data_a;
            if (pops_a == cap_base_a + 1) cap1_a = out_data_a;
            void'(q_a.pop_front());
            pops_a++;
            if (row_idx_a == 7) begin done_exp_a = 1'b1; row_idx_a = 0; end
            else row_idx_a++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      seen_rst_b = 1'b1; done_exp_b = 1'b0; row_idx_b = 0;
    end else if (seen_rst_b) begin
      chk("b_done", done_b, done_exp_b);
      if (done_b) done_cnt_b++;
      done_exp_b = 1'b0;
      if (out_valid_b) begin
        if (q_b.size() == 0) chk("b_spurious_valid", out_valid_b, 1'b0);
        else begin
          chk("b_row", out_data_b, q_b[0]);
          if (out_ready_b) begin
            void'(q_b.pop_front());
            pops_b++;
            if (row_idx_b == 3) begin done_exp_b = 1'b1; row_idx_b = 0; end
            else row_idx_b++;
          end
        end
      end
    end
  end

  // Called and returns at posedge+1.
  task automatic send_beat_a(input logic [127:0] d);
    bit ok = 0;
    in_valid_a = 1'b1;
    in_data_a  = d;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready_a) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    chk("a_beat_accepted", ok, 1);
  endtask

  task automatic send_beat_b(input logic [255:0] d);
    bit ok = 0;
    in_valid_b = 1'b1;
    in_data_b  = d;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready_b) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    chk("b_beat_accepted", ok, 1);
  endtask

  task automatic send_matrix_a(input int mode, input bit push, input int nbeats, input bit lat);
    logic [15:0]  el [48];
    logic [95:0]  rows [8];
    logic [127:0] d;
    int r, k;
    for (int n = 0; n < 48; n++) el[n] = (mode == 0) ? 16'(n << 8) : 16'($urandom_range(0, 65535));
    if (push) begin
      for (int i = 0; i < 8; i++) rows[i] = '0;
      for (int n = 0; n < 48; n++) begin
        map_pos(n, 6, 2, 2, r, k);
        rows[r][k*16 +: 16] = el[n];
      end
      for (int i = 0; i < 8; i++) q_a.push_back(rows[i]);
    end
    for (int b = 0; b < nbeats; b++) begin
      for (int e = 0; e < 8; e++) d[e*16 +: 16] = el[b*8 + e];
      if (lat && b == 5) begin
        @(negedge clk); chk("a_valid_before_last_beat", out_valid_a, 1'b0);
        @(posedge clk); #1;
      end
      send_beat_a(d);
      if (lat && b == 5) begin
        @(negedge clk); chk("a_valid_latency", out_valid_a, 1'b1);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic send_matrix_b();
    logic [15:0]  el [32];
    logic [127:0] rows [4];
    logic [255:0] d;
    int r, k;
    for (int n = 0; n < 32; n++) el[n] = 16'($urandom_range(0, 65535));
    for (int i = 0; i < 4; i++) rows[i] = '0;
    for (int n = 0; n < 32; n++) begin
      map_pos(n, 8, 2, 4, r, k);
      rows[r][k*16 +: 16] = el[n];
    end
    for (int i = 0; i < 4; i++) q_b.push_back(rows[i]);
    for (int b = 0; b < 2; b++) begin
      for (int e = 0; e < 16; e++) d[e*16 +: 16] = el[b*16 + e];
      send_beat_b(d);
    end
  endtask

  task automatic drain_a(input string tag);
    for (int t = 0; t < 400; t++) begin
      if (q_a.size() == 0) break;
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(tag, q_a.size(), 0);
  endtask

  initial begin
    int base_done, base_pops, cnt;
    logic [127:0] garbage;
    rst = 1'b1;
    in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready_a, 1'b0);
    chk("rst_out_valid", out_valid_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready_a, 1'b1);
    chk("post_rst_out_valid", out_valid_a, 1'b0);
    @(posedge clk); #1;

    // Reference ramp matrix, latency, known row values
    cap_base_a = pops_a;
    send_matrix_a(0, 1, 6, 1);
    drain_a("ramp_drain");
    chk("ramp_row0", cap0_a, 96'h0900_0800_0500_0400_0100_0000);
    chk("ramp_row1", cap1_a, 96'h0b00_0a00_0700_0600_0300_0200);
    chk("ramp_done_count", done_cnt_a, 1);

    // Two matrices with the sink stalled, then garbage while both banks full
    out_ready_a = 1'b0;
    base_done = done_cnt_a;
    send_matrix_a(1, 1, 6, 0);
    @(negedge clk); chk("one_bank_full_in_ready", in_ready_a, 1'b1);
    @(posedge clk); #1;
    send_matrix_a(1, 1, 6, 0);
    @(negedge clk); chk("both_full_in_ready", in_ready_a, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      garbage = {$urandom, $urandom, $urandom, $urandom};
      in_valid_a = 1'b1; in_data_a = garbage;
      @(negedge clk); chk("garbage_in_ready", in_ready_a, 1'b0);
    end
    @(posedge clk); #1;
    in_valid_a = 1'b0; out_ready_a = 1'b1;
    cnt = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (out_valid_a && out_ready_a) begin
        cnt++;
        if (cnt == 8) begin
          chk("in_ready_at_row7", in_ready_a, 1'b0);
          @(negedge clk);
          chk("in_ready_after_row7", in_ready_a, 1'b1);
          break;
        end
      end
    end
    chk("row7_reached", cnt, 8);
    @(posedge clk); #1;
    drain_a("pair_drain");
    chk("pair_done_count", done_cnt_a - base_done, 2);

    // Sink toggling every cycle
    out_ready_a = 1'b0;
    base_done = done_cnt_a; base_pops = pops_a;
    send_matrix_a(1, 1, 6, 0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      out_ready_a = ~out_ready_a;
    end
    out_ready_a = 1'b1;
    drain_a("toggle_drain");
    chk("toggle_rows", pops_a - base_pops, 8);
    chk("toggle_done_count", done_cnt_a - base_done, 1);

    // Reset mid-matrix discards the partial matrix
    send_matrix_a(1, 0, 3, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(negedge clk); chk("mid_rst_in_ready", in_ready_a, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_out_valid", out_valid_a, 1'b0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    base_done = done_cnt_a; cap_base_a = pops_a;
    send_matrix_a(0, 1, 6, 1);
    drain_a("post_rst_drain");
    chk("post_rst_row0", cap0_a, 96'h0900_0800_0500_0400_0100_0000);
    chk("post_rst_row1", cap1_a, 96'h0b00_0a00_0700_0600_0300_0200);
    chk("post_rst_done_count", done_cnt_a - base_done, 1);

    // Parameter sweep instance: 3 random matrices
    base_done = done_cnt_b;
    for (int m = 0; m < 3; m++) send_matrix_b();
    for (int t = 0; t < 200; t++) begin
      if (q_b.size() == 0) break;
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sweep_drain", q_b.size(), 0);
    chk("sweep_done_count", done_cnt_b - base_done, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/b2r_pingpong_converter.md
B2R_PINGPONG_CONVERTER -- requirements
Module: b2r_pingpong_converter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, element width in bits.
REQ-002 SHALL have parameter FRAC_WIDTH, default 8, fixed-point fraction bits; informational only, data is moved bit-exact with no arithmetic.
REQ-003 SHALL have parameter ROW, default 8, matrix rows.
REQ-004 SHALL have parameter COL, default 6, matrix columns.
REQ-005 SHALL have parameter BLOCK_SIZE, default 2, square block edge.
REQ-006 SHALL have parameter NUM_CORES, default 2, blocks carried per input beat.
REQ-007 SHALL derive: CHUNK_SIZE=BLOCK_SIZE^2; ELEM_PER_INPUT=CHUNK_SIZE*NUM_CORES; BLK_PER_ROW=COL/BLOCK_SIZE; BEATS=(ROW*COL)/ELEM_PER_INPUT.
REQ-008 SHALL fail elaboration unless BLOCK_SIZE divides ROW and COL, and NUM_CORES divides (ROW/BLOCK_SIZE)*BLK_PER_ROW.
REQ-009 clk  in  1  single clock; all logic on rising edge.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 in_valid  in  1  input beat valid.
REQ-012 in_ready  out  1  converter can accept a beat.
REQ-013 in_data  in  WIDTH*ELEM_PER_INPUT  packed block elements.
REQ-014 out_valid  out  1  out_data holds a valid row.
REQ-015 out_ready  in  1  downstream accepts the row.
REQ-016 out_data  out  WIDTH*COL  one matrix row; column k at bits [k*WIDTH +: WIDTH].
REQ-017 done  out  1  one-cycle pulse: a full matrix has been emitted.

Function
REQ-018 Input handshake SHALL occur on in_valid&in_ready at a rising edge; output handshake on out_valid&out_ready.
REQ-019 Beat b, core c, element j at in_data[(c*CHUNK_SIZE+j)*WIDTH +: WIDTH] SHALL map to block g=b*NUM_CORES+c, row (g/BLK_PER_ROW)*BLOCK_SIZE+j/BLOCK_SIZE, col (g%BLK_PER_ROW)*BLOCK_SIZE+j%BLOCK_SIZE.
REQ-020 Storage SHALL be two banks (ping-pong) of ROW*COL words, each with a full flag; write pointer wr_bank, beat counter 0..BEATS-1; read pointer rd_bank, row counter 0..ROW-1.
REQ-021 in_ready SHALL equal !rst && !full[wr_bank].
REQ-022 On the handshake of beat BEATS-1: full[wr_bank] set, wr_bank toggled, beat counter cleared, all in the same edge.
REQ-023 out_valid SHALL equal full[rd_bank]; out_data SHALL be row row_cnt of bank rd_bank, combinationally muxed from storage.
REQ-024 Latency: out_valid SHALL rise the cycle after the final input beat handshake when rd_bank is that bank.
REQ-025 Each output handshake SHALL advance row_cnt; rows emitted 0..ROW-1 in order, back-to-back while out_ready stays high.
REQ-026 On handshake of row ROW-1: full[rd_bank] cleared, rd_bank toggled, row_cnt cleared, done registered high for exactly the next cycle.
REQ-027 Bank full-flag set (writer) and clear (reader) on different banks in the same edge SHALL both take effect.
REQ-028 With both banks full, in_ready SHALL be low; it SHALL rise the cycle after the reader frees a bank.
REQ-029 out_data SHALL hold stable while out_valid&!out_ready.
REQ-030 in_valid while in_ready is low SHALL be ignored; no storage write.
REQ-031 Writer SHALL fill one bank while the reader drains the other; sustained throughput: one matrix per max(BEATS,ROW) cycles.

Reset
REQ-032 While rst is high at an edge: full flags, wr_bank, rd_bank, counters, and done SHALL clear to 0.
REQ-033 During and after reset: out_valid=0, done=0, in_ready=0 while rst high, in_ready=1 the first cycle after release.
REQ-034 Storage contents SHALL NOT be reset; reset mid-matrix SHALL discard partial and pending matrices.

Verification
REQ-035 Defaults, element n=n<<8 in stream order, 6 beats, out_ready=1 -> row0 cols0..5 = 0000 0100 0400 0500 0800 0900; row1 = 0200 0300 0600 0700 0a00 0b00; 8 rows, done pulse one cycle after row7.
REQ-036 Two matrices back-to-back, out_ready=0 -> in_ready drops after 12th beat; raise out_ready -> in_ready rises the cycle after the first matrix's 8th row; second matrix data correct.
REQ-037 out_ready toggling 1/0 every cycle -> each row is emitted exactly once, with data held while stalled; done count = 1.
REQ-038 in_valid high while in_ready=0 with distinct garbage data -> no corruption of stored matrices.
REQ-039 rst pulsed after beat 3 -> out_valid stays 0; a fresh 6-beat matrix then produces the REQ-035 output.
REQ-040 Parameter sweep ROW=4, COL=8, BLOCK_SIZE=2, NUM_CORES=4 -> row-major output matches a reference model for 3 random matrices.
